// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: long-latency write scoreboard that stalls decode on
// RAW/WAW, plus nearest-stage-wins operand bypass selects for the X stage.

module hazard_fwd_pick #(
  parameter int AW   = 5,
  parameter int NFWD = 3,
  parameter int SW   = 2
) (
  input  logic [AW-1:0]      rs,
  input  logic               rs_en,
  input  logic [NFWD*AW-1:0] fwd_rd,
  input  logic [NFWD-1:0]    fwd_en,
  output logic [SW-1:0]      sel
);
  logic [NFWD-1:0] hit;

  for (genvar k = 0; k < NFWD; k++) begin : g_hit
    assign hit[k] = rs_en && fwd_en[k] && (fwd_rd[k*AW +: AW] == rs) && (rs != '0);
  end

  // Walk oldest to nearest so the nearest matching stage overwrites the rest.
  always_comb begin
    sel = '0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (hit[k]) sel = SW'(k + 1);
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int NFWD    = 3,
  parameter int SW      = 2,
  parameter int MAX_OUT = 4,
  parameter int CW      = $clog2(MAX_OUT + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               d_valid,
  input  logic [AW-1:0]      d_rs1,
  input  logic [AW-1:0]      d_rs2,
  input  logic [AW-1:0]      d_rd,
  input  logic               d_rs1_en,
  input  logic               d_rs2_en,
  input  logic               d_rd_en,
  input  logic               d_long,
  output logic               d_stall,
  output logic               d_issue,
  input  logic [AW-1:0]      x_rs1,
  input  logic [AW-1:0]      x_rs2,
  input  logic               x_rs1_en,
  input  logic               x_rs2_en,
  input  logic [NFWD*AW-1:0] fwd_rd,
  input  logic [NFWD-1:0]    fwd_en,
  output logic [SW-1:0]      a_sel,
  output logic [SW-1:0]      b_sel,
  input  logic               wb_valid,
  input  logic [AW-1:0]      wb_rd,
  output logic [CW-1:0]      out_cnt,
  output logic               sb_err
);
  typedef struct packed {
    logic [AW-1:0] idx;
    logic          en;
  } src_t;

  src_t [1:0]         x_src;
  logic [1:0][SW-1:0] x_sel;

  logic [NREG-1:0] busy_q, busy_d, clr_mask, set_mask, eff_busy;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            haz, cap, set_en, clr_en, dec_ok;

  // ---------------- scoreboard ----------------
  assign clr_en   = wb_valid && (wb_rd != '0);
  assign clr_mask = clr_en ? (NREG'(1) << wb_rd) : '0;
  assign eff_busy = busy_q & ~clr_mask;

  assign haz = (d_rs1_en && eff_busy[d_rs1]) ||
               (d_rs2_en && eff_busy[d_rs2]) ||
               (d_rd_en  && eff_busy[d_rd]);

  assign cap = d_long && d_rd_en && (d_rd != '0) &&
               (cnt_q == CW'(MAX_OUT)) && !wb_valid;

  assign d_stall = d_valid && (haz || cap);
  assign d_issue = d_valid && !d_stall;

  assign set_en   = d_issue && d_long && d_rd_en && (d_rd != '0);
  assign set_mask = set_en ? (NREG'(1) << d_rd) : '0;
  assign dec_ok   = clr_en && (cnt_q != '0);

  always_comb begin
    // Set applied after clear so a same-register reissue keeps the bit.
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;
    cnt_d     = cnt_q + CW'(set_en) - CW'(dec_ok);
    err_d     = err_q || (clr_en && (!busy_q[wb_rd] || cnt_q == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign out_cnt = cnt_q;
  assign sb_err  = err_q;

  // ---------------- operand forwarding ----------------
  assign x_src[0] = '{idx: x_rs1, en: x_rs1_en};
  assign x_src[1] = '{idx: x_rs2, en: x_rs2_en};

  for (genvar i = 0; i < 2; i++) begin : g_op
    hazard_fwd_pick #(.AW(AW), .NFWD(NFWD), .SW(SW)) u_pick (
      .rs     (x_src[i].idx),
      .rs_en  (x_src[i].en),
      .fwd_rd (fwd_rd),
      .fwd_en (fwd_en),
      .sel    (x_sel[i])
    );
  end

  assign a_sel = x_sel[0];
  assign b_sel = x_sel[1];
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: scoreboard stalls, capacity limit,
// same-cycle set/clear, error flag and forwarding priority.

module tb_hazard_scoreboard;
  localparam int AW = 5, NFWD = 3, SW = 2, CW = 3;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               d_valid, d_rs1_en, d_rs2_en, d_rd_en, d_long;
  logic [AW-1:0]      d_rs1, d_rs2, d_rd;
  logic               d_stall, d_issue;
  logic [AW-1:0]      x_rs1, x_rs2;
  logic               x_rs1_en, x_rs2_en;
  logic [NFWD*AW-1:0] fwd_rd;
  logic [NFWD-1:0]    fwd_en;
  logic [SW-1:0]      a_sel, b_sel;
  logic               wb_valid;
  logic [AW-1:0]      wb_rd;
  logic [CW-1:0]      out_cnt;
  logic               sb_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .reset_n(reset_n),
    .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_rs1_en(d_rs1_en), .d_rs2_en(d_rs2_en), .d_rd_en(d_rd_en), .d_long(d_long),
    .d_stall(d_stall), .d_issue(d_issue),
    .x_rs1(x_rs1), .x_rs2(x_rs2), .x_rs1_en(x_rs1_en), .x_rs2_en(x_rs2_en),
    .fwd_rd(fwd_rd), .fwd_en(fwd_en), .a_sel(a_sel), .b_sel(b_sel),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .out_cnt(out_cnt), .sb_err(sb_err)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decode drive: long op to rd, or a consumer of rs1.
  task automatic dec(input logic v, input int rs1, input logic rs1e,
                     input int rd, input logic rde, input logic lng);
    d_valid  = v;
    d_rs1    = AW'(rs1);
    d_rs1_en = rs1e;
    d_rs2    = '0;
    d_rs2_en = 1'b0;
    d_rd     = AW'(rd);
    d_rd_en  = rde;
    d_long   = lng;
  endtask

  task automatic wb(input logic v, input int rd);
    wb_valid = v;
    wb_rd    = AW'(rd);
  endtask

  // Drive at negedge, settle, then sample well away from the rising edge.
  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    dec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    wb(1'b0, 0);
    x_rs1 = '0; x_rs2 = '0; x_rs1_en = 1'b0; x_rs2_en = 1'b0;
    fwd_rd = '0; fwd_en = '0;

    // Reset state with a plain decode present
    step;
    d_valid = 1'b1; d_rs1 = 5'd5; d_rs1_en = 1'b1; d_rs2 = 5'd6; d_rs2_en = 1'b1;
    #1;
    chk("rst_stall", d_stall, 0);
    chk("rst_issue", d_issue, 1);
    chk("rst_cnt",   out_cnt, 0);
    chk("rst_err",   sb_err,  0);
    chk("rst_asel",  a_sel,   0);
    step; reset_n = 1'b1;
    step; #1;
    chk("plain_issue", d_issue, 1);

    // RAW against a long op, released in the completion cycle
    dec(1'b1, 0, 1'b0, 7, 1'b1, 1'b1); #1;
    chk("long7_issue", d_issue, 1);
    step; dec(1'b1, 7, 1'b1, 0, 1'b0, 1'b0); #1;
    chk("long7_cnt", out_cnt, 1);
    chk("raw7_stall", d_stall, 1);
    step; #1;
    chk("raw7_hold", d_stall, 1);
    wb(1'b1, 7); #1;
    chk("raw7_wb_stall", d_stall, 0);
    chk("raw7_wb_issue", d_issue, 1);
    step; wb(1'b0, 0); #1;
    chk("raw7_after_stall", d_stall, 0);
    chk("raw7_after_cnt", out_cnt, 0);
    chk("raw7_err", sb_err, 0);

    // Fill to MAX_OUT, fifth long op waits for a completion
    for (int i = 1; i <= 4; i++) begin
      step; dec(1'b1, 0, 1'b0, i, 1'b1, 1'b1); #1;
      chk("fill_issue", d_issue, 1);
    end
    step; dec(1'b1, 0, 1'b0, 9, 1'b1, 1'b1); #1;
    chk("full_cnt", out_cnt, 4);
    chk("cap_stall", d_stall, 1);
    step; #1;
    chk("cap_hold", d_stall, 1);
    wb(1'b1, 1); #1;
    chk("cap_wb_issue", d_issue, 1);
    step; dec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0); wb(1'b0, 0); #1;
    chk("cap_net_cnt", out_cnt, 4);
    begin
      int drain[4] = '{2, 3, 4, 9};
      for (int i = 0; i < 4; i++) begin
        wb(1'b1, drain[i]);
        step;
      end
    end
    wb(1'b0, 0); #1;
    chk("drain_cnt", out_cnt, 0);
    chk("drain_err", sb_err, 0);

    // Same-cycle clear and reissue of register 8
    dec(1'b1, 0, 1'b0, 8, 1'b1, 1'b1);
    step; #1;
    chk("r8_cnt", out_cnt, 1);
    wb(1'b1, 8); #1;
    chk("r8_waw_stall", d_stall, 0);
    step; wb(1'b0, 0); dec(1'b1, 8, 1'b1, 0, 1'b0, 1'b0); #1;
    chk("r8_same_cnt", out_cnt, 1);
    chk("r8_still_busy", d_stall, 1);
    chk("r8_err", sb_err, 0);
    dec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0); wb(1'b1, 8);
    step; wb(1'b0, 0); #1;
    chk("r8_drain_cnt", out_cnt, 0);

    // Forwarding priority
    fwd_rd = {5'd10, 5'd10, 5'd10}; fwd_en = 3'b111;
    x_rs1 = 5'd10; x_rs1_en = 1'b1; #1;
    chk("fwd_near", a_sel, 1);
    fwd_en = 3'b110; #1;
    chk("fwd_stage2", a_sel, 2);
    x_rs1 = 5'd0; #1;
    chk("fwd_x0", a_sel, 0);
    x_rs2 = 5'd10; x_rs2_en = 1'b1; fwd_en = 3'b100; #1;
    chk("fwd_b_oldest", b_sel, 3);
    x_rs2_en = 1'b0; #1;
    chk("fwd_b_disabled", b_sel, 0);
    fwd_rd = {5'd11, 5'd11, 5'd3}; fwd_en = 3'b111; x_rs2 = 5'd11; x_rs2_en = 1'b1; #1;
    chk("fwd_b_mixed", b_sel, 2);

    // Spurious completion: sticky error, no underflow
    step; wb(1'b1, 12);
    step; wb(1'b0, 0); #1;
    chk("err_set", sb_err, 1);
    chk("err_no_underflow", out_cnt, 0);
    step; step; #1;
    chk("err_sticky", sb_err, 1);
    reset_n = 1'b0; #1;
    chk("err_rst", sb_err, 0);

    // Reset mid-flight discards entries; a late completion errors
    step; reset_n = 1'b1;
    dec(1'b1, 0, 1'b0, 13, 1'b1, 1'b1);
    step; dec(1'b0, 0, 1'b0, 0, 1'b0, 1'b0); #1;
    chk("mid_cnt", out_cnt, 1);
    reset_n = 1'b0; #1;
    chk("mid_rst_cnt", out_cnt, 0);
    step; reset_n = 1'b1; wb(1'b1, 13);
    step; wb(1'b0, 0); #1;
    chk("late_wb_err", sb_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
